neuron_seq_mac: RTL and testbench
=================================

// Module: neuron_seq_mac
// PURPOSE
// - Sequential, parametrised successor to the combinational single-neuron evaluator.
// - Latches one N-input vector, its weights and activation bounds; accumulates LANES products/cycle
//   over ceil(N/LANES) cycles, then averages, clamps and scales to one unit_t output.
// - valid/ready on both sides; one neuron per evaluation; sits between layer sequencer and output buffer.
// PARAMETERS
// - N      16  inputs per neuron; >=1; also the averaging divisor
// - LANES   4  multipliers per cycle; 1..N; N need not be a multiple of LANES
// - localparam CHUNKS = (N+LANES-1)/LANES; CW = $clog2(CHUNKS+1)
// PORTS
// - clk        in   1                 single clock; all state updates on rising edge
// - rst        in   1                 synchronous, active-high reset
// - in_valid   in   1                 request valid
// - in_ready   out  1                 block can accept a request
// - in         in   unit_t[N]         input activations
// - weights    in   unit_signed_t[N]  per-input weights
// - act_upper  in   unit_signed_t     activation upper bound
// - act_lower  in   unit_signed_t     activation lower bound
// - out_valid  out  1                 result valid
// - out_ready  in   1                 consumer accepts result
// - out        out  unit_t            neuron output
// BEHAVIOUR
// - Reset: state=IDLE, chunk counter=0, sum=`frac_zero, out_valid=0, out=`unit_min; in_ready=0 while rst=1.
// - States: IDLE -> ACCUM -> FINISH -> HOLD -> IDLE.
//   IDLE:   in_ready=1; on in_valid: latch in/weights/bounds, sum<=`frac_zero, cnt<=0, go ACCUM.
//   ACCUM:  sum<=frac_add over lanes j of unit_mul_frac(in[cnt*LANES+j], weights[cnt*LANES+j]);
//           lanes with index >=N add zero; cnt++; after chunk CHUNKS-1 go FINISH.
//   FINISH: average=frac_to_unit_signed_overflow_to_max_min(frac_signed_div_int(sum,N));
//           register out and flags; out_valid<=1; go HOLD.
//   HOLD:   out/flags stable while out_valid=1; on out_ready clear out_valid, go IDLE.
// - in_ready is 1 only in IDLE; inputs ignored in other states; latched copies only used after accept.
// - Latency: accept at edge E; out_valid=1 after edge E+CHUNKS+1; min period CHUNKS+3 cycles.
// - Accumulation order fixed: chunk 0 first, lanes ascending within chunk; saturation is frac_add's.
// - Clamp priority, checked in order:
//   1) average < act_lower: out=`unit_min
//   2) average > act_upper: out=`unit_max
//   3) otherwise: out=unit_signed_scale(average, act_lower, unit_signed_abs_unit(act_upper-act_lower))
// - act_lower > act_upper: rule 1 still wins; rule 2 applies only if average >= act_lower.
// - out_ready while out_valid=0 has no effect.
// - rst during ACCUM/FINISH/HOLD: partial sum and pending result dropped, no out_valid pulse, IDLE next cycle.
// - rst and in_valid together: reset wins, request not accepted.
// CONFIGURATION
// - NEURON_SEQ_STATUS_EN defined: adds outputs, registered in FINISH, valid with out_valid:
//     average    out unit_signed_t
//     too_big    out 1  (rule 2 taken)
//     too_small  out 1  (rule 1 taken)
//   All three reset to 0.
// - Undefined: these ports and their registers are absent; out timing and value are identical.
// TESTING
// - N=16,LANES=4; all in=`unit_max, weights max positive, act_upper=0, act_lower=min
//   -> out=`unit_max 5 cycles after accept; too_big=1 with STATUS_EN.
// - N=16,LANES=3 (6 chunks, last ragged); in[i]=i, weights alternating +/-
//   -> out equals combinational golden model; out_valid 7 cycles after accept.
// - Weights all zero, act_lower<0<act_upper -> average=0; out=unit_signed_scale(0,lower,space);
//   both flags 0.
// - Backpressure: out_ready held 0 for 10 cycles -> out/out_valid stable, in_ready=0 throughout;
//   1 cycle after out_ready=1: in_ready=1.
// - rst pulsed in 2nd ACCUM cycle -> no out_valid; next request gives a result independent of the aborted one.
// - act_lower > act_upper with average between them -> rule 1 first; average above lower -> `unit_max.

Source files
------------

// File: rtl/neuron_seq_mac.sv
// Sequential single-neuron evaluator: latches one N-input vector, accumulates LANES products per
// cycle, then averages, clamps and scales to one unit. Define NEURON_SEQ_STATUS_EN for status outputs.
//
// Number formats:
//   unit          8-bit unsigned, value = u/256, range [0, 1)
//   unit_signed   9-bit two's complement, value = s/256, range [-1, 1)
//   frac          24-bit two's complement accumulator, value = f/65536 (product scale)
module neuron_seq_mac #(
   parameter int N     = 16,
   parameter int LANES = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N*8-1:0] in,
   input  logic [N*9-1:0] weights,
   input  logic [8:0]     act_upper,
   input  logic [8:0]     act_lower,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [7:0]     out
`ifdef NEURON_SEQ_STATUS_EN
   ,
   output logic [8:0]     average,
   output logic           too_big,
   output logic           too_small
`endif
);

   localparam int UW     = 8;
   localparam int SW     = 9;
   localparam int PW     = UW + SW + 1;
   localparam int FW     = 24;
   localparam int CHUNKS = (N + LANES - 1) / LANES;
   localparam int CW     = $clog2(CHUNKS + 1);
   localparam int CIW    = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
   localparam int CDEPTH = 1 << CIW;

   localparam logic [UW-1:0]        UNIT_MIN  = '0;
   localparam logic [UW-1:0]        UNIT_MAX  = '1;
   localparam logic signed [FW-1:0] FRAC_ZERO = '0;
   localparam logic signed [FW-1:0] FRAC_MAX  = {1'b0, {(FW-1){1'b1}}};
   localparam logic signed [FW-1:0] FRAC_MIN  = {1'b1, {(FW-1){1'b0}}};
   localparam logic signed [FW-1:0] N_FRAC    = FW'(N);
   localparam logic signed [FW-1:0] SU_MAX_F  = FW'(255);
   localparam logic signed [FW-1:0] SU_MIN_F  = -(FW'(256));

   typedef enum logic [1:0] {IDLE, ACCUM, FINISH, HOLD} state_t;

   state_t                 state_q;
   logic [CW-1:0]          cnt_q;
   logic signed [FW-1:0]   sum_q;
   logic signed [FW-1:0]   sum_d;
   logic                   out_valid_q;
   logic [UW-1:0]          out_q;
   logic [UW-1:0]          out_d;
   logic signed [SW-1:0]   lower_q;
   logic signed [SW-1:0]   upper_q;

   logic [UW-1:0]          x_pad [CDEPTH][LANES];
   logic signed [SW-1:0]   w_pad [CDEPTH][LANES];
   logic [UW-1:0]          x_q   [CDEPTH][LANES];
   logic signed [SW-1:0]   w_q   [CDEPTH][LANES];
   logic signed [PW-1:0]   prod  [LANES];

   logic [CIW-1:0]         cidx;
   logic                   accept;

   logic signed [FW-1:0]   quot;
   logic signed [FW-1:0]   shifted;
   logic signed [SW-1:0]   avg_d;
   logic                   rule_small;
   logic                   rule_big;
   logic [SW:0]            rel;
   logic signed [SW:0]     diff;
   logic [SW:0]            abs_diff;
   logic [UW-1:0]          space;
   logic [SW+UW:0]         num;
   logic [SW+UW:0]         quo;
   logic [UW-1:0]          scaled;

`ifdef NEURON_SEQ_STATUS_EN
   logic signed [SW-1:0]   average_q;
   logic                   too_big_q;
   logic                   too_small_q;
`endif

   assign in_ready  = (state_q == IDLE) && !rst;
   assign accept    = (state_q == IDLE) && in_valid;
   assign cidx      = cnt_q[CIW-1:0];
   assign out_valid = out_valid_q;
   assign out       = out_q;

   // Saturating frac addition; order of calls fixes the accumulation order.
   function automatic logic signed [FW-1:0] frac_add(input logic signed [FW-1:0] a,
                                                     input logic signed [FW-1:0] b);
      logic [FW:0] s;
      s = {a[FW-1], a} + {b[FW-1], b};
      if (s[FW] != s[FW-1])
         return s[FW] ? FRAC_MIN : FRAC_MAX;
      return s[FW-1:0];
   endfunction

   // Chunk-major storage; lanes past N and rows past CHUNKS hold zero so they add nothing.
   for (genvar gc = 0; gc < CDEPTH; gc++) begin : g_chunk
      for (genvar gl = 0; gl < LANES; gl++) begin : g_lane
         localparam int IDX = gc * LANES + gl;
         if (IDX < N) begin : g_used
            assign x_pad[gc][gl] = in[IDX*UW +: UW];
            assign w_pad[gc][gl] = weights[IDX*SW +: SW];
         end else begin : g_pad
            assign x_pad[gc][gl] = '0;
            assign w_pad[gc][gl] = '0;
         end
      end
   end

   for (genvar gl = 0; gl < LANES; gl++) begin : g_mul
      assign prod[gl] = $signed({{(PW-UW){1'b0}}, x_q[cidx][gl]})
                      * $signed({{(PW-SW){w_q[cidx][gl][SW-1]}}, w_q[cidx][gl]});
   end

   always_comb begin
      sum_d = sum_q;
      for (int j = 0; j < LANES; j++)
         sum_d = frac_add(sum_d, {{(FW-PW){prod[j][PW-1]}}, prod[j]});
   end

   // Average: divide truncates toward zero, frac->unit_signed floors, then saturates.
   always_comb begin
      quot    = sum_q / N_FRAC;
      shifted = quot >>> 8;
      if (shifted > SU_MAX_F)
         avg_d = 9'sd255;
      else if (shifted < SU_MIN_F)
         avg_d = -9'sd256;
      else
         avg_d = shifted[SW-1:0];

      rule_small = avg_d < lower_q;
      rule_big   = !rule_small && (avg_d > upper_q);

      rel      = {avg_d[SW-1], avg_d} - {lower_q[SW-1], lower_q};
      diff     = $signed({upper_q[SW-1], upper_q}) - $signed({lower_q[SW-1], lower_q});
      abs_diff = diff[SW] ? 10'(-diff) : 10'(diff);
      space    = (abs_diff > 10'd255) ? UNIT_MAX : abs_diff[UW-1:0];

      // Position of the average inside [lower, upper] as a unit; empty range maps to max.
      num = {rel, 8'h00};
      quo = num / {{(SW+1){1'b0}}, ((space == '0) ? 8'd1 : space)};
      if (space == '0 || quo > 18'd255)
         scaled = UNIT_MAX;
      else
         scaled = quo[UW-1:0];

      if (rule_small)
         out_d = UNIT_MIN;
      else if (rule_big)
         out_d = UNIT_MAX;
      else
         out_d = scaled;
   end

   always_ff @(posedge clk) begin
      if (!rst && accept) begin
         x_q     <= x_pad;
         w_q     <= w_pad;
         lower_q <= act_lower;
         upper_q <= act_upper;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         sum_q       <= FRAC_ZERO;
         out_valid_q <= 1'b0;
         out_q       <= UNIT_MIN;
`ifdef NEURON_SEQ_STATUS_EN
         average_q   <= '0;
         too_big_q   <= 1'b0;
         too_small_q <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  sum_q   <= FRAC_ZERO;
                  cnt_q   <= '0;
                  state_q <= ACCUM;
               end
            end
            ACCUM: begin
               sum_q <= sum_d;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CW'(CHUNKS - 1))
                  state_q <= FINISH;
            end
            FINISH: begin
               out_q       <= out_d;
               out_valid_q <= 1'b1;
`ifdef NEURON_SEQ_STATUS_EN
               average_q   <= avg_d;
               too_big_q   <= rule_big;
               too_small_q <= rule_small;
`endif
               state_q     <= HOLD;
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef NEURON_SEQ_STATUS_EN
   assign average   = average_q;
   assign too_big   = too_big_q;
   assign too_small = too_small_q;
`endif

endmodule

// File: tb/tb_neuron_seq_mac.sv
// Directed bench for neuron_seq_mac: LANES=4 and ragged LANES=3 instances, hand-computed results.
// Status outputs are checked when NEURON_SEQ_STATUS_EN is defined.
module tb_neuron_seq_mac;

   logic           clk;
   logic           rst;
   logic           in_valid_a;
   logic           in_valid_b;
   logic           out_ready;
   logic [16*8-1:0] in_v;
   logic [16*9-1:0] w_v;
   logic [8:0]     up;
   logic [8:0]     lo;

   logic           in_ready_a, out_valid_a;
   logic [7:0]     out_a;
   logic           in_ready_b, out_valid_b;
   logic [7:0]     out_b;
`ifdef NEURON_SEQ_STATUS_EN
   logic [8:0]     average_a, average_b;
   logic           too_big_a, too_big_b, too_small_a, too_small_b;
`endif

   int total = 0;
   int bad   = 0;

   neuron_seq_mac #(.N(16), .LANES(4)) dut_a (
      .clk(clk), .rst(rst),
      .in_valid(in_valid_a), .in_ready(in_ready_a),
      .in(in_v), .weights(w_v), .act_upper(up), .act_lower(lo),
      .out_valid(out_valid_a), .out_ready(out_ready), .out(out_a)
`ifdef NEURON_SEQ_STATUS_EN
      , .average(average_a), .too_big(too_big_a), .too_small(too_small_a)
`endif
   );

   neuron_seq_mac #(.N(16), .LANES(3)) dut_b (
      .clk(clk), .rst(rst),
      .in_valid(in_valid_b), .in_ready(in_ready_b),
      .in(in_v), .weights(w_v), .act_upper(up), .act_lower(lo),
      .out_valid(out_valid_b), .out_ready(out_ready), .out(out_b)
`ifdef NEURON_SEQ_STATUS_EN
      , .average(average_b), .too_big(too_big_b), .too_small(too_small_b)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic load_vec(input logic [7:0] x, input logic signed [8:0] w,
                           input logic [8:0] upper, input logic [8:0] lower);
      for (int i = 0; i < 16; i++) begin
         in_v[i*8 +: 8] = x;
         w_v[i*9 +: 9]  = w;
      end
      up = upper;
      lo = lower;
   endtask

   task automatic run_a(output int lat);
      @(negedge clk);
      in_valid_a = 1'b1;
      @(posedge clk);
      #1 in_valid_a = 1'b0;
      lat = -1;
      for (int c = 1; c <= 30; c++) begin
         @(posedge clk);
         #1;
         if (out_valid_a) begin
            lat = c;
            break;
         end
      end
      $display("req A: latency=%0d out=%0d", lat, out_a);
   endtask

   task automatic release_out();
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_valid_a = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      total++; if (in_ready_a !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%0d want=0", in_ready_a); end
      total++; if (out_valid_a !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0d want=0", out_valid_a); end
      total++; if (out_a !== 8'd0) begin bad++; $display("FAIL reset_out got=%0d want=0", out_a); end
`ifdef NEURON_SEQ_STATUS_EN
      total++; if (average_a !== 9'd0 || too_big_a !== 1'b0 || too_small_a !== 1'b0) begin
         bad++; $display("FAIL reset_status got=%0d/%0d/%0d want=0/0/0", average_a, too_big_a, too_small_a); end
`endif
      rst = 1'b0;
      in_valid_a = 1'b0;
      @(posedge clk);
      #1;
      total++; if (in_ready_a !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready got=%0d want=1", in_ready_a); end
      total++; if (out_valid_a !== 1'b0) begin bad++; $display("FAIL post_reset_out_valid got=%0d want=0", out_valid_a); end
      total++; if (in_ready_b !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready_b got=%0d want=1", in_ready_b); end
      $display("reset: done");
   endtask

   // in=255, w=255: avg = floor((16*65025/16)/256) = 254 > upper 0 -> unit_max.
   task automatic test_saturate_high();
      int lat;
      load_vec(8'd255, 9'sd255, 9'd0, 9'h100);
      run_a(lat);
      total++; if (lat !== 5) begin bad++; $display("FAIL sat_latency got=%0d want=5", lat); end
      total++; if (out_a !== 8'd255) begin bad++; $display("FAIL sat_out got=%0d want=255", out_a); end
`ifdef NEURON_SEQ_STATUS_EN
      total++; if (too_big_a !== 1'b1 || too_small_a !== 1'b0) begin
         bad++; $display("FAIL sat_flags got=%0d/%0d want=1/0", too_big_a, too_small_a); end
      total++; if (average_a !== 9'd254) begin bad++; $display("FAIL sat_average got=%0d want=254", average_a); end
`endif
      release_out();
   endtask

   // in[i]=i, w=+100/-100: sum=-800, /16=-50, floor(-50/256)=-1; rel=9, space=20 -> 2304/20=115.
   task automatic test_ragged_lanes();
      int lat;
      for (int i = 0; i < 16; i++) begin
         in_v[i*8 +: 8] = 8'(i);
         w_v[i*9 +: 9]  = (i % 2 == 0) ? 9'sd100 : -9'sd100;
      end
      up = 9'sd10;
      lo = -9'sd10;
      @(negedge clk);
      in_valid_b = 1'b1;
      @(posedge clk);
      #1 in_valid_b = 1'b0;
      lat = -1;
      for (int c = 1; c <= 30; c++) begin
         @(posedge clk);
         #1;
         if (out_valid_b) begin
            lat = c;
            break;
         end
      end
      $display("req B: latency=%0d out=%0d", lat, out_b);
      total++; if (lat !== 7) begin bad++; $display("FAIL ragged_latency got=%0d want=7", lat); end
      total++; if (out_b !== 8'd115) begin bad++; $display("FAIL ragged_out got=%0d want=115", out_b); end
`ifdef NEURON_SEQ_STATUS_EN
      total++; if (average_b !== 9'h1FF) begin bad++; $display("FAIL ragged_average got=%0d want=511(-1)", average_b); end
      total++; if (too_big_b !== 1'b0 || too_small_b !== 1'b0) begin
         bad++; $display("FAIL ragged_flags got=%0d/%0d want=0/0", too_big_b, too_small_b); end
`endif
      release_out();
   endtask

   // Zero weights, bounds -128..128: space saturates to 255, 128*256/255 = 128.
   task automatic load_zero_weights();
      for (int i = 0; i < 16; i++) begin
         in_v[i*8 +: 8] = 8'(i * 16);
         w_v[i*9 +: 9]  = 9'd0;
      end
      up = 9'sd128;
      lo = -9'sd128;
   endtask

   task automatic test_zero_weights();
      int lat;
      load_zero_weights();
      run_a(lat);
      total++; if (lat !== 5) begin bad++; $display("FAIL zero_latency got=%0d want=5", lat); end
      total++; if (out_a !== 8'd128) begin bad++; $display("FAIL zero_out got=%0d want=128", out_a); end
`ifdef NEURON_SEQ_STATUS_EN
      total++; if (average_a !== 9'd0) begin bad++; $display("FAIL zero_average got=%0d want=0", average_a); end
      total++; if (too_big_a !== 1'b0 || too_small_a !== 1'b0) begin
         bad++; $display("FAIL zero_flags got=%0d/%0d want=0/0", too_big_a, too_small_a); end
`endif
      release_out();
   endtask

   task automatic test_backpressure();
      int lat;
      load_zero_weights();
      run_a(lat);
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         #1;
         total++; if (out_valid_a !== 1'b1) begin bad++; $display("FAIL bp_out_valid cycle=%0d got=%0d want=1", c, out_valid_a); end
         total++; if (out_a !== 8'd128) begin bad++; $display("FAIL bp_out cycle=%0d got=%0d want=128", c, out_a); end
         total++; if (in_ready_a !== 1'b0) begin bad++; $display("FAIL bp_in_ready cycle=%0d got=%0d want=0", c, in_ready_a); end
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      total++; if (out_valid_a !== 1'b0) begin bad++; $display("FAIL bp_release_valid got=%0d want=0", out_valid_a); end
      total++; if (in_ready_a !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%0d want=1", in_ready_a); end
      $display("backpressure: held 10 cycles");
   endtask

   task automatic test_reset_abort();
      int lat;
      logic seen;
      load_vec(8'd255, 9'sd255, 9'd0, 9'h100);
      @(negedge clk);
      in_valid_a = 1'b1;
      @(posedge clk);
      #1 in_valid_a = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         #1;
         if (out_valid_a) seen = 1'b1;
      end
      $display("abort: reset in second accumulate cycle");
      total++; if (seen !== 1'b0) begin bad++; $display("FAIL abort_no_valid got=%0d want=0", seen); end
      total++; if (in_ready_a !== 1'b1) begin bad++; $display("FAIL abort_idle got=%0d want=1", in_ready_a); end
      load_zero_weights();
      run_a(lat);
      total++; if (lat !== 5) begin bad++; $display("FAIL abort_next_latency got=%0d want=5", lat); end
      total++; if (out_a !== 8'd128) begin bad++; $display("FAIL abort_next_out got=%0d want=128", out_a); end
      release_out();
   endtask

   // lower=100 > upper=50. in=150,w=128 -> avg 75 (below lower); in=240 -> avg 120 (above both).
   task automatic test_inverted_bounds();
      int lat;
      load_vec(8'd150, 9'sd128, 9'sd50, 9'sd100);
      run_a(lat);
      total++; if (out_a !== 8'd0) begin bad++; $display("FAIL inv_low_out got=%0d want=0", out_a); end
`ifdef NEURON_SEQ_STATUS_EN
      total++; if (average_a !== 9'd75) begin bad++; $display("FAIL inv_low_average got=%0d want=75", average_a); end
      total++; if (too_small_a !== 1'b1 || too_big_a !== 1'b0) begin
         bad++; $display("FAIL inv_low_flags got=%0d/%0d want=1/0", too_small_a, too_big_a); end
`endif
      release_out();
      load_vec(8'd240, 9'sd128, 9'sd50, 9'sd100);
      run_a(lat);
      total++; if (out_a !== 8'd255) begin bad++; $display("FAIL inv_high_out got=%0d want=255", out_a); end
`ifdef NEURON_SEQ_STATUS_EN
      total++; if (average_a !== 9'd120) begin bad++; $display("FAIL inv_high_average got=%0d want=120", average_a); end
      total++; if (too_small_a !== 1'b0 || too_big_a !== 1'b1) begin
         bad++; $display("FAIL inv_high_flags got=%0d/%0d want=0/1", too_small_a, too_big_a); end
`endif
      release_out();
   endtask

   initial begin
      rst        = 1'b1;
      in_valid_a = 1'b0;
      in_valid_b = 1'b0;
      out_ready  = 1'b0;
      in_v       = '0;
      w_v        = '0;
      up         = '0;
      lo         = '0;
      test_reset();
      test_saturate_high();
      test_ragged_lanes();
      test_zero_weights();
      test_backpressure();
      test_reset_abort();
      test_inverted_bounds();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
